// File: rtl/mod_fp_add_sub.sv
// Four-stage pipelined floating-point adder/subtractor with round-to-nearest-even.
// Subnormals are treated as zero. NaN results are canonical quiet NaNs.
module mod_fp_add_sub #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [EXP_W+MAN_W:0]     in_A,
  input  logic [EXP_W+MAN_W:0]     in_B,
  input  logic                     in_Sub,
  input  logic                     in_En,
  output logic [EXP_W+MAN_W:0]     out_Out,
  output logic                     out_Ready,
  output logic                     out_Overflow,
  output logic                     out_Invalid
);
  localparam int W      = 1 + EXP_W + MAN_W;
  localparam int MX     = MAN_W + 4;             // hidden + frac + guard/round/sticky
  localparam int MR     = MAN_W + 2;             // rounded mantissa incl. carry
  localparam int EW     = EXP_W + $clog2(MX) + 2; // exponent with headroom for borrow
  localparam int STAGES = 3;
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [EW-1:0]    EMAX     = EW'((1 << EXP_W) - 1);

  typedef struct packed {
    logic         spec;
    logic         inv;
    logic [W-1:0] val;
  } spec_t;

  typedef struct packed {
    spec_t            sp;
    logic             sign;
    logic             eff_sub;
    logic [EXP_W-1:0] exp;
    logic [EXP_W-1:0] diff;
    logic [MAN_W:0]   man_big;
    logic [MAN_W:0]   man_small;
  } s1_t;

  typedef struct packed {
    spec_t            sp;
    logic             sign;
    logic             eff_sub;
    logic [EXP_W-1:0] exp;
    logic [MAN_W:0]   man_big;
    logic [MX-1:0]    small_al;
  } s2_t;

  typedef struct packed {
    spec_t         sp;
    logic          sign;
    logic          zero;
    logic [EW-1:0] exp;
    logic [MX-1:0] nm;
  } s3_t;

  logic [STAGES:0] vld_pipe;
  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;
  s3_t s3_d, s3_q;

  // S1: unpack, apply subtract, order by magnitude, detect special results
  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_big;
  logic [W-2:0]     mag_a, mag_b;

  always_comb begin
    sa     = in_A[W-1];
    sb     = in_B[W-1] ^ in_Sub;
    ea     = in_A[W-2:MAN_W];
    eb     = in_B[W-2:MAN_W];
    fa     = in_A[MAN_W-1:0];
    fb     = in_B[MAN_W-1:0];
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_inf  = (ea == EXP_ONES) && (fa == '0);
    b_inf  = (eb == EXP_ONES) && (fb == '0);
    a_nan  = (ea == EXP_ONES) && (fa != '0);
    b_nan  = (eb == EXP_ONES) && (fb != '0);
    mag_a  = a_zero ? '0 : in_A[W-2:0];
    mag_b  = b_zero ? '0 : in_B[W-2:0];
    a_big  = (mag_a >= mag_b);

    s1_d         = '0;
    s1_d.eff_sub = sa ^ sb;
    if (a_big) begin
      s1_d.sign      = sa;
      s1_d.exp       = ea;
      s1_d.diff      = ea - eb;
      s1_d.man_big   = a_zero ? '0 : {1'b1, fa};
      s1_d.man_small = b_zero ? '0 : {1'b1, fb};
    end else begin
      s1_d.sign      = sb;
      s1_d.exp       = eb;
      s1_d.diff      = eb - ea;
      s1_d.man_big   = b_zero ? '0 : {1'b1, fb};
      s1_d.man_small = a_zero ? '0 : {1'b1, fa};
    end

    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
      s1_d.sp.spec = 1'b1;
      s1_d.sp.inv  = 1'b1;
      s1_d.sp.val  = QNAN;
    end else if (a_inf || b_inf) begin
      s1_d.sp.spec = 1'b1;
      s1_d.sp.val  = {a_inf ? sa : sb, EXP_ONES, {MAN_W{1'b0}}};
    end else if (a_zero && b_zero) begin
      s1_d.sp.spec = 1'b1;
      s1_d.sp.val  = {sa & sb, {(W-1){1'b0}}};
    end
  end

  // S2: align the smaller operand, folding shifted-out bits into sticky
  logic [MX-1:0] ext_small, shifted;

  always_comb begin
    ext_small = {s1_q.man_small, 3'b000};
    shifted   = '0;
    if (32'(s1_q.diff) >= MAN_W + 3) begin
      shifted[0] = |s1_q.man_small;
    end else begin
      shifted    = ext_small >> s1_q.diff;
      shifted[0] = shifted[0] | (|(ext_small & ~({MX{1'b1}} << s1_q.diff)));
    end
    s2_d          = '0;
    s2_d.sp       = s1_q.sp;
    s2_d.sign     = s1_q.sign;
    s2_d.eff_sub  = s1_q.eff_sub;
    s2_d.exp      = s1_q.exp;
    s2_d.man_big  = s1_q.man_big;
    s2_d.small_al = shifted;
  end

  // S3: add/subtract magnitudes, then normalise (carry right, leading zeros left)
  logic [MX:0]   big_x, small_x, sum;
  logic [EW-1:0] lz, exp_n;
  logic [MX-1:0] nm;
  logic          found;

  always_comb begin
    big_x   = {1'b0, s2_q.man_big, 3'b000};
    small_x = {1'b0, s2_q.small_al};
    sum     = s2_q.eff_sub ? (big_x - small_x) : (big_x + small_x);
    lz      = '0;
    found   = 1'b0;
    for (int i = MX - 1; i >= 0; i--) begin
      if (!found && sum[i]) begin
        lz    = EW'(MX - 1 - i);
        found = 1'b1;
      end
    end
    if (sum[MX]) begin
      nm    = {sum[MX:2], sum[1] | sum[0]};
      exp_n = EW'(s2_q.exp) + EW'(1);
    end else begin
      nm    = sum[MX-1:0] << lz;
      exp_n = EW'(s2_q.exp) - lz;
    end
    s3_d      = '0;
    s3_d.sp   = s2_q.sp;
    s3_d.nm   = nm;
    s3_d.exp  = exp_n;
    // exact cancellation is +0; underflow flushes to a zero carrying the result sign
    s3_d.sign = (sum == '0) ? 1'b0 : s2_q.sign;
    s3_d.zero = (sum == '0) || exp_n[EW-1] || (exp_n == '0);
  end

  // S4: round to nearest even, renormalise on carry, pack
  logic          rnd_up;
  logic [MR-1:0] mant_r;
  logic [EW-1:0] exp_r;
  logic [MAN_W-1:0] frac_r;
  logic [W-1:0]  res;
  logic          res_ovf, res_inv;

  always_comb begin
    rnd_up  = s3_q.nm[2] & (s3_q.nm[3] | s3_q.nm[1] | s3_q.nm[0]);
    mant_r  = {1'b0, s3_q.nm[MX-1:3]} + MR'(rnd_up);
    exp_r   = s3_q.exp + EW'(mant_r[MR-1]);
    frac_r  = mant_r[MR-1] ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];
    res     = {s3_q.sign, exp_r[EXP_W-1:0], frac_r};
    res_ovf = 1'b0;
    res_inv = 1'b0;
    if (s3_q.sp.spec) begin
      res     = s3_q.sp.val;
      res_inv = s3_q.sp.inv;
    end else if (s3_q.zero) begin
      res = {s3_q.sign, {(W-1){1'b0}}};
    end else if (exp_r >= EMAX) begin
      res     = {s3_q.sign, EXP_ONES, {MAN_W{1'b0}}};
      res_ovf = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe     <= '0;
      out_Out      <= '0;
      out_Overflow <= 1'b0;
      out_Invalid  <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], in_En};
      if (vld_pipe[STAGES-1]) begin
        out_Out      <= res;
        out_Overflow <= res_ovf;
        out_Invalid  <= res_inv;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_En)       s1_q <= s1_d;
    if (vld_pipe[0]) s2_q <= s2_d;
    if (vld_pipe[1]) s3_q <= s3_d;
  end

  assign out_Ready = vld_pipe[STAGES];

endmodule

// File: tb/tb_mod_fp_add_sub.sv
// Directed-vector bench for mod_fp_add_sub with a queue scoreboard and an independent monitor.
module tb_mod_fp_add_sub;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] in_A = '0, in_B = '0;
  logic         in_Sub = 1'b0, in_En = 1'b0;
  logic [W-1:0] out_Out;
  logic         out_Ready, out_Overflow, out_Invalid;

  mod_fp_add_sub #(.EXP_W(5), .MAN_W(10)) dut (
    .clk(clk), .rst(rst), .in_A(in_A), .in_B(in_B), .in_Sub(in_Sub), .in_En(in_En),
    .out_Out(out_Out), .out_Ready(out_Ready), .out_Overflow(out_Overflow), .out_Invalid(out_Invalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] o;
    logic         ovf;
    logic         inv;
    int           cyc;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] o;
    logic         ovf;
    logic         inv;
  } vec_t;

  exp_t         sb_q[$];
  exp_t         mon_e;
  int           total = 0, bad = 0, cyc = 0;
  logic [W-1:0] last_out = '0;
  logic         last_ovf = 1'b0, last_inv = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor: pops on every out_Ready, otherwise checks that the last result is held
  always @(negedge clk) begin
    if (!rst) begin
      if (out_Ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_ready", 32'd1, 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          chk("out", 32'(out_Out), 32'(mon_e.o));
          chk("overflow", 32'(out_Overflow), 32'(mon_e.ovf));
          chk("invalid", 32'(out_Invalid), 32'(mon_e.inv));
          chk("latency", cyc, mon_e.cyc);
          last_out = mon_e.o;
          last_ovf = mon_e.ovf;
          last_inv = mon_e.inv;
        end
      end else begin
        chk("hold", 32'({out_Out, out_Overflow, out_Invalid}), 32'({last_out, last_ovf, last_inv}));
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       input logic [W-1:0] o, input logic ovf, input logic inv);
    exp_t e;
    @(posedge clk); #1;
    in_A = a; in_B = b; in_Sub = sub; in_En = 1'b1;
    e.o = o; e.ovf = ovf; e.inv = inv; e.cyc = cyc + 4;
    sb_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_En = 1'b0;
    end
  endtask

  vec_t vecs[] = '{
    '{16'h3C00, 16'h3C00, 1'b0, 16'h4000, 1'b0, 1'b0},  // 1+1
    '{16'h7800, 16'h7800, 1'b0, 16'h7C00, 1'b1, 1'b0},  // overflow to +Inf
    '{16'h6800, 16'h3C00, 1'b0, 16'h6800, 1'b0, 1'b0},  // tie, round to even (down)
    '{16'h6800, 16'h4200, 1'b0, 16'h6802, 1'b0, 1'b0},  // tie, round to even (up)
    '{16'h3C00, 16'h3C00, 1'b1, 16'h0000, 1'b0, 1'b0},  // exact cancellation
    '{16'h4000, 16'h4200, 1'b1, 16'hBC00, 1'b0, 1'b0},  // 2-3
    '{16'h7C00, 16'h7C00, 1'b1, 16'h7E00, 1'b0, 1'b1},  // Inf-Inf
    '{16'h8000, 16'h8000, 1'b0, 16'h8000, 1'b0, 1'b0},  // -0 + -0
    '{16'h0000, 16'h8000, 1'b0, 16'h0000, 1'b0, 1'b0},  // +0 + -0
    '{16'h7C00, 16'h3C00, 1'b0, 16'h7C00, 1'b0, 1'b0},  // Inf + 1
    '{16'h3C00, 16'hFC00, 1'b1, 16'h7C00, 1'b0, 1'b0},  // 1 - (-Inf)
    '{16'h7C00, 16'h7C00, 1'b0, 16'h7C00, 1'b0, 1'b0},  // Inf + Inf
    '{16'h7C01, 16'h3C00, 1'b0, 16'h7E00, 1'b0, 1'b1},  // NaN input
    '{16'h0001, 16'h3C00, 1'b0, 16'h3C00, 1'b0, 1'b0},  // subnormal as zero
    '{16'h3C00, 16'hBC00, 1'b1, 16'h4000, 1'b0, 1'b0},  // 1 - (-1)
    '{16'h7800, 16'h3C00, 1'b0, 16'h7800, 1'b0, 1'b0},  // full sticky collapse
    '{16'h3BFF, 16'h0C00, 1'b0, 16'h3C00, 1'b0, 1'b0},  // rounding carry renormalises
    '{16'h7BFF, 16'h4C00, 1'b0, 16'h7C00, 1'b1, 1'b0},  // rounding overflow
    '{16'h0401, 16'h0400, 1'b1, 16'h0000, 1'b0, 1'b0},  // underflow flush +0
    '{16'h0400, 16'h0401, 1'b1, 16'h8000, 1'b0, 1'b0}   // underflow flush -0
  };

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out", 32'(out_Out), 32'd0);
    chk("reset_ready", 32'(out_Ready), 32'd0);
    chk("reset_flags", 32'({out_Overflow, out_Invalid}), 32'd0);
    rst = 1'b0;
    idle(2);

    foreach (vecs[i]) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].o, vecs[i].ovf, vecs[i].inv);
      idle(1);
    end
    idle(6);

    // back-to-back issue, then the same ops with a bubble in the middle
    issue(16'h3C00, 16'h3C00, 1'b0, 16'h4000, 1'b0, 1'b0);
    issue(16'h4000, 16'h4200, 1'b1, 16'hBC00, 1'b0, 1'b0);
    issue(16'h3C00, 16'h3C00, 1'b1, 16'h0000, 1'b0, 1'b0);
    idle(1);
    issue(16'h3C00, 16'h3C00, 1'b0, 16'h4000, 1'b0, 1'b0);
    idle(1);
    issue(16'h4000, 16'h4200, 1'b1, 16'hBC00, 1'b0, 1'b0);
    issue(16'h7800, 16'h7800, 1'b0, 16'h7C00, 1'b1, 1'b0);
    idle(8);

    // reset with two ops in flight: both are discarded
    issue(16'h3C00, 16'h3C00, 1'b0, 16'h4000, 1'b0, 1'b0);
    issue(16'h4000, 16'h4200, 1'b1, 16'hBC00, 1'b0, 1'b0);
    @(posedge clk); #1;
    in_En = 1'b0;
    rst   = 1'b1;
    sb_q.delete();
    @(posedge clk); #1;
    chk("rst_mid_out", 32'(out_Out), 32'd0);
    chk("rst_mid_ready", 32'(out_Ready), 32'd0);
    chk("rst_mid_flags", 32'({out_Overflow, out_Invalid}), 32'd0);
    last_out = '0; last_ovf = 1'b0; last_inv = 1'b0;
    rst = 1'b0;
    idle(6);
    issue(16'h6800, 16'h4200, 1'b0, 16'h6802, 1'b0, 1'b0);
    idle(1);

    for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(posedge clk);
    chk("drain", sb_q.size(), 32'd0);
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
